dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_DEPTH, 6501, number of words in the data memory; valid addresses are 0..MEM_DEPTH-1.
REQ-002 Parameter CNT_W, 16, width of the per-requester grant counters.
REQ-003 Clocking is one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock, shared with the data memory.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 reqN_valid  input  1  requester N (N=0 pipeline MEM stage, N=1 loader/debug) has a command.
REQ-007 reqN_write  input  1  command is a write (1) or a read (0).
REQ-008 reqN_addr  input  32  word address of the command.
REQ-009 reqN_wdata  input  32  write data.
REQ-010 reqN_ready  output  1  command of requester N is accepted this cycle.
REQ-011 reqN_rvalid  output  1  one-cycle response pulse to requester N.
REQ-012 reqN_rdata  output  32  read data, valid with reqN_rvalid.
REQ-013 reqN_err  output  1  out-of-range error, valid with reqN_rvalid.
REQ-014 mem_address, mem_write_data  output  32 each  memory command.
REQ-015 mem_read, mem_write  output  1 each  memory strobes.
REQ-016 mem_read_data  input  32  combinational memory read data.
REQ-017 grant_cnt0, grant_cnt1  output  CNT_W each  saturating accepted-command counters.

Function
REQ-018 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on accept; ACCESS->RESP always; RESP->ACCESS on accept, else RESP->IDLE.
REQ-019 Accept is allowed only in IDLE or RESP; reqN_ready asserts combinationally for exactly the requester selected by arbitration; at most one ready per cycle.
REQ-020 Arbitration is round-robin: priority pointer selects the preferred requester when both are valid; the sole valid requester wins regardless of pointer.
REQ-021 On accept, the pointer moves to the non-granted requester.
REQ-022 On accept, the command (id, write, addr, wdata) is registered; requester inputs are ignored afterwards.
REQ-023 In ACCESS, mem_address/mem_write_data drive the registered command; mem_read=1 for an in-range read and mem_write=1 for an in-range write; all other cycles both strobes are 0.
REQ-024 In ACCESS, mem_read_data is captured at the closing clock edge; a write completes in memory at that same edge.
REQ-025 In RESP, rvalid of the owning requester is 1 for one cycle; rdata = captured data for reads, 0 for writes; no backpressure on responses.
REQ-026 Latency: accept at edge T, memory access cycle T..T+1, rvalid high in cycle T+1..T+2; peak throughput one command per 2 cycles.
REQ-027 Address >= MEM_DEPTH: no memory strobe in ACCESS, response has err=1, rdata=0.
REQ-028 grant_cntN increments on each accept of requester N and saturates at all-ones (no wrap).
REQ-029 A requester may drop valid without being granted; no state is kept for it.

Reset
REQ-030 While rst=0: state IDLE, pointer = requester 0, command register 0, all ready/rvalid/err/rdata 0, mem strobes 0, mem_address/mem_write_data 0, counters 0.
REQ-031 Reset during ACCESS aborts the command: no response is issued, and a write whose edge coincides with reset assertion is not guaranteed.
REQ-032 First accept is possible in the first cycle after rst deasserts.

Structure
REQ-033 Shared package dmem_pkg holds the state enum (IDLE/ACCESS/RESP), the requester-id type, and MEM_DEPTH default.
REQ-034 One sub-module rr_arb2 (2-way round-robin pick plus pointer register); FSM, command register, and counters remain in dmem_arbiter.

Verification
REQ-035 Single read: memory[20]=0xCAFE0001, req0 read addr 20 -> req0_ready 1 cycle, mem_read in next cycle, req0_rvalid with rdata 0xCAFE0001, err 0, two cycles after accept.
REQ-036 Contention: both valid continuously after reset -> grants alternate 0,1,0,1; grant_cnt0=grant_cnt1 after even count; never two ready at once.
REQ-037 Write-then-read: req1 writes 0x12345678 to addr 100, then req0 reads 100 -> req1 rvalid with rdata 0, req0 rdata 0x12345678.
REQ-038 Out of range: req0 read addr 6501 -> mem_read and mem_write stay 0, req0_rvalid with err 1, rdata 0.
REQ-039 Reset mid-operation: assert rst during ACCESS -> no rvalid, all outputs 0, pointer 0; both valid after release -> req0 granted first.
REQ-040 Saturation: CNT_W=2, five req0 accepts -> grant_cnt0 holds 3.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester id,
// the registered command record and the address range helper.
package dmem_pkg;

  localparam int MEM_DEPTH_DEFAULT = 6501;
  localparam int ADDR_W            = 32;
  localparam int DATA_W            = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // 0 = pipeline MEM stage, 1 = loader/debug port
  typedef logic req_id_t;

  typedef struct packed {
    req_id_t             id;
    logic                write;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
  } cmd_t;

  // True when the word address falls inside the memory.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker. The pointer names the requester preferred
// when both are valid; after every grant it moves to the other one.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic       gnt_vld,
  output req_id_t    gnt_id
);

  req_id_t ptr_q;

  // Pick the sole valid requester, or the pointer's choice under contention.
  always_comb begin
    gnt_id  = 1'b0;
    gnt_vld = en && (valid != 2'b00);
    if (valid == 2'b11) gnt_id = ptr_q;
    else if (valid[1])  gnt_id = 1'b1;
    else                gnt_id = 1'b0;
  end

  // Priority pointer: hand preference to the loser of each grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ptr_q <= 1'b0;
    else if (gnt_vld) ptr_q <= ~gnt_id;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto a single-port data memory. One command is
// in flight at a time: accept, one memory cycle, one response cycle.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [31:0]       req0_addr,
  input  logic [31:0]       req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [31:0]       req0_rdata,
  output logic              req0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [31:0]       req1_addr,
  input  logic [31:0]       req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [31:0]       req1_rdata,
  output logic              req1_err,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_read_data,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(MEM_DEPTH);

  state_t            state_q, state_d;
  cmd_t              cmd_p0;
  logic [DATA_W-1:0] rsp_data_p1;
  logic              rsp_err_p1;
  logic              accept_en, accept, in_range;
  req_id_t           gnt_id;

  // Readiness is held off while reset is asserted so no grant leaks out.
  assign accept_en = rst && ((state_q == IDLE) || (state_q == RESP));
  assign in_range  = addr_in_range(cmd_p0.addr, DEPTH_L);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (accept_en),
    .valid   ({req1_valid, req0_valid}),
    .gnt_vld (accept),
    .gnt_id  (gnt_id)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: a response cycle can chain straight into a new access.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = accept ? ACCESS : IDLE;
      ACCESS:  state_d = RESP;
      RESP:    state_d = accept ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- stage p0: command captured at accept ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_p0 <= '0;
    end else if (accept) begin
      if (gnt_id) cmd_p0 <= {1'b1, req1_write, req1_addr, req1_wdata};
      else        cmd_p0 <= {1'b0, req0_write, req0_addr, req0_wdata};
    end
  end

  // ---- stage p1: memory result captured at the end of the access cycle ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_data_p1 <= '0;
      rsp_err_p1  <= 1'b0;
    end else if (state_q == ACCESS) begin
      rsp_data_p1 <= (!cmd_p0.write && in_range) ? mem_read_data : '0;
      rsp_err_p1  <= !in_range;
    end
  end

  // Saturating per-requester grant counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (accept) begin
      if (!gnt_id && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if ( gnt_id && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
    end
  end

  // Output decode: ready from the arbiter, memory bus in ACCESS, response in RESP.
  always_comb begin
    req0_ready     = accept && !gnt_id;
    req1_ready     = accept &&  gnt_id;
    req0_rvalid    = 1'b0;
    req1_rvalid    = 1'b0;
    req0_rdata     = '0;
    req1_rdata     = '0;
    req0_err       = 1'b0;
    req1_err       = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    case (state_q)
      ACCESS: begin
        mem_address    = cmd_p0.addr;
        mem_write_data = cmd_p0.wdata;
        mem_read       = in_range && !cmd_p0.write;
        mem_write      = in_range &&  cmd_p0.write;
      end
      RESP: begin
        if (cmd_p0.id) begin
          req1_rvalid = 1'b1;
          req1_rdata  = rsp_data_p1;
          req1_err    = rsp_err_p1;
        end else begin
          req0_rvalid = 1'b1;
          req0_rdata  = rsp_data_p1;
          req0_err    = rsp_err_p1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table plus hand sequences for contention,
// reset during an access and counter saturation. Responses are scored
// against a queue filled when each command is accepted.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int DEPTH = 6501;
  localparam int CW    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic req0_valid, req0_write, req0_ready, req0_rvalid, req0_err;
  logic req1_valid, req1_write, req1_ready, req1_rvalid, req1_err;
  logic [31:0] req0_addr, req0_wdata, req0_rdata;
  logic [31:0] req1_addr, req1_wdata, req1_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic mem_read, mem_write;
  logic [CW-1:0] grant_cnt0, grant_cnt1;

  dmem_arbiter #(.MEM_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  // Memory: combinational read, write at the clock edge. Junk when not read.
  logic [31:0] mem     [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  assign mem_read_data = (mem_read && mem_address < DEPTH) ? mem[mem_address] : 32'hBAD0_0BAD;
  always @(posedge clk) if (mem_write && mem_address < DEPTH) mem[mem_address] <= mem_write_data;

  typedef struct { logic id; logic [31:0] rdata; logic err; } rsp_t;
  rsp_t sbq[$];

  typedef struct {
    logic v0, v1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    logic exp_id;
    logic [1:0] exp_strobe; // {mem_read, mem_write}
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push on accept, pop on response.
  always @(negedge clk) begin : mon
    rsp_t e, x;
    logic [31:0] a;
    if (!rst) begin
      sbq.delete();
    end else begin
      if (req0_rvalid || req1_rvalid) begin
        check("rvalid_onehot", {63'd0, req0_rvalid & req1_rvalid}, 64'd0);
        check("rvalid_expected", {63'd0, sbq.size() > 0}, 64'd1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check("rsp_id", {63'd0, req1_rvalid}, {63'd0, e.id});
          check("rsp_rdata", req1_rvalid ? req1_rdata : req0_rdata, e.rdata);
          check("rsp_err", {63'd0, req1_rvalid ? req1_err : req0_err}, {63'd0, e.err});
        end
      end
      if (req0_ready || req1_ready) begin
        check("ready_onehot", {63'd0, req0_ready & req1_ready}, 64'd0);
        x.id  = req1_ready;
        a     = req1_ready ? req1_addr : req0_addr;
        x.err = (a >= DEPTH);
        if (x.err) x.rdata = 32'd0;
        else if (req1_ready ? req1_write : req0_write) begin
          x.rdata    = 32'd0;
          ref_mem[a] = req1_ready ? req1_wdata : req0_wdata;
        end else x.rdata = ref_mem[a];
        sbq.push_back(x);
      end
    end
  end

  function automatic vec_t mk(input logic v0, v1, w0, w1, input logic [31:0] a0, a1, d0, d1,
                              input logic id, input logic [1:0] st);
    vec_t t;
    t.v0 = v0; t.v1 = v1; t.w0 = w0; t.w1 = w1;
    t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
    t.exp_id = id; t.exp_strobe = st;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    req0_valid = t.v0; req0_write = t.w0; req0_addr = t.a0; req0_wdata = t.d0;
    req1_valid = t.v1; req1_write = t.w1; req1_addr = t.a1; req1_wdata = t.d1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
  endtask

  // Apply one command, check grant, memory cycle and response latency.
  task automatic run_vec(input vec_t t);
    bit got;
    @(posedge clk); #1;
    drive(t);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) got = 1;
    end
    check("accept_seen", {63'd0, got}, 64'd1);
    if (got) begin
      check("grant_id", {63'd0, req1_ready}, {63'd0, t.exp_id});
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("strobe", {62'd0, mem_read, mem_write}, {62'd0, t.exp_strobe});
      if (t.exp_strobe != 2'b00) check("mem_addr", mem_address, t.exp_id ? t.a1 : t.a0);
      if (t.exp_strobe == 2'b01) check("mem_wdata", mem_write_data, t.exp_id ? t.d1 : t.d0);
      check("busy_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
      @(negedge clk);
      check("rvalid_latency", {63'd0, t.exp_id ? req1_rvalid : req0_rvalid}, 64'd1);
    end else begin
      @(posedge clk); #1;
      idle_inputs();
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sbq.size() > 0; k++) @(negedge clk);
    check("drain", sbq.size(), 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {50'd0, req0_ready, req1_ready, req0_rvalid, req1_rvalid,
                           req0_err, req1_err, mem_read, mem_write, grant_cnt0, grant_cnt1}, 64'd0);
    check({name, "_bus"}, {mem_address, mem_write_data}, 64'd0);
    check({name, "_rdata"}, {req0_rdata, req1_rdata}, 64'd0);
  endtask

  vec_t tbl[10];

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int grants, first_cyc;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'h5A00_0000 ^ i;
      ref_mem[i] = 32'h5A00_0000 ^ i;
    end
    mem[20] = 32'hCAFE_0001; ref_mem[20] = 32'hCAFE_0001;

    tbl[0] = mk(1, 0, 0, 0, 20,   0,    0, 0,            0, 2'b10);
    tbl[1] = mk(0, 1, 0, 1, 0,    100,  0, 32'h12345678, 1, 2'b01);
    tbl[2] = mk(1, 0, 0, 0, 100,  0,    0, 0,            0, 2'b10);
    tbl[3] = mk(1, 0, 0, 0, 6501, 0,    0, 0,            0, 2'b00);
    tbl[4] = mk(1, 1, 0, 0, 5,    6,    0, 0,            1, 2'b10);
    tbl[5] = mk(1, 1, 1, 0, 7,    8,    32'hAAAA5555, 0, 0, 2'b01);
    tbl[6] = mk(1, 0, 0, 0, 7,    0,    0, 0,            0, 2'b10);
    tbl[7] = mk(0, 1, 0, 1, 0,    32'hFFFFFFFF, 0, 32'h1, 1, 2'b00);
    tbl[8] = mk(0, 1, 0, 0, 0,    6500, 0, 0,            1, 2'b10);
    tbl[9] = mk(1, 1, 0, 1, 0,    0,    0, 32'h77,       0, 2'b10);

    // Reset values, with both requesters asking.
    rst = 0;
    req0_write = 0; req0_addr = 0; req0_wdata = 0;
    req1_write = 0; req1_addr = 0; req1_wdata = 0;
    idle_inputs();
    @(posedge clk); #1;
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    check_all_zero("reset");
    idle_inputs();
    @(posedge clk); #1;
    rst = 1;

    for (int i = 0; i < 10; i++) run_vec(tbl[i]);
    drain();
    check("cnt0_table", {62'd0, grant_cnt0}, 64'd3);
    check("cnt1_table", {62'd0, grant_cnt1}, 64'd3);

    // Contention straight out of reset: 0,1,0,1 and first accept immediately.
    @(posedge clk); #1;
    rst = 0;
    drive(mk(1, 1, 0, 0, 20, 21, 0, 0, 0, 2'b00));
    @(posedge clk); #1;
    rst = 1;
    grants = 0; first_cyc = -1;
    for (int c = 0; c < 30 && grants < 4; c++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        if (first_cyc < 0) first_cyc = c;
        check("rr_order", {63'd0, req1_ready}, {63'd0, grants[0]});
        grants++;
        if (grants == 4) begin
          @(posedge clk); #1;
          idle_inputs();
        end
      end
    end
    check("rr_grants", grants, 64'd4);
    check("first_accept_cycle", first_cyc, 64'd0);
    idle_inputs();
    drain();
    check("cnt_equal", {60'd0, grant_cnt0, grant_cnt1}, {60'd0, 2'd2, 2'd2});

    // Reset during ACCESS after the pointer has moved to requester 1.
    run_vec(mk(1, 0, 0, 0, 30, 0, 0, 0, 0, 2'b10));
    drain();
    @(posedge clk); #1;
    drive(mk(1, 0, 0, 0, 31, 0, 0, 0, 0, 2'b00));
    @(negedge clk);
    check("pre_abort_ready", {62'd0, req0_ready, req1_ready}, 64'd2);
    @(posedge clk); #1;
    idle_inputs();
    #2 rst = 0;
    @(negedge clk);
    check_all_zero("abort");
    req0_valid = 1; req1_valid = 1; req0_addr = 32; req1_addr = 33;
    @(negedge clk);
    check_all_zero("abort_hold");
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    check("ptr_after_reset", {62'd0, req1_ready, req0_ready}, 64'd1);
    @(posedge clk); #1;
    idle_inputs();
    drain();

    // Counter saturation.
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
    for (int i = 0; i < 5; i++) run_vec(mk(1, 0, 0, 0, 40 + i, 0, 0, 0, 0, 2'b10));
    drain();
    check("cnt0_saturate", {62'd0, grant_cnt0}, 64'd3);
    check("cnt1_idle", {62'd0, grant_cnt1}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
